// File: rtl/fir_pkg.sv
// Shared types and constants for the 9-tap FIR coefficient configurator.
package fir_pkg;

    localparam int ORDER      = 8;
    localparam int DATA_WIDTH = 13;

    typedef logic signed [DATA_WIDTH-1:0] coef_t;
    typedef coef_t [0:ORDER]              coef_bank_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Host-side configuration bus: shadow write port, commit strobe and status flags.
interface fir_coef_ctrl_if
    import fir_pkg::*;
    ();

    logic       CFG_WE;
    logic [3:0] CFG_ADDR;
    coef_t      CFG_DATA;
    logic       CFG_COMMIT;
    logic       BUSY;
    logic       SWAP_DONE;
    logic       FORCED;
    logic       WR_ERR;

    modport master (
        output CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        input  BUSY, SWAP_DONE, FORCED, WR_ERR
    );

    modport slave (
        input  CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        output BUSY, SWAP_DONE, FORCED, WR_ERR
    );

endinterface

// File: rtl/fir_drain_mon.sv
// Tracks consecutive idle samples and total wait time while a commit is pending.
module fir_drain_mon #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_WAIT     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    input  logic vin_i,
    output logic drained_o,
    output logic timeout_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] idle_q, idle_d;
    logic [CW-1:0] wait_q, wait_d;

    always_comb begin
        idle_d = idle_q;
        wait_d = wait_q;
        if (clear_i) begin
            idle_d = '0;
            wait_d = '0;
        end else if (enable_i) begin
            wait_d = wait_q + CW'(1);
            if (vin_i)
                idle_d = '0;
            else if (idle_q != IDLE_MAX)
                idle_d = idle_q + CW'(1);
        end
    end

    // Conditions look at the pre-edge counts so the swap lands on the qualifying edge.
    assign drained_o = enable_i && !vin_i && (idle_q == IDLE_LAST);
    assign timeout_o = enable_i && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            wait_q <= '0;
        end else begin
            idle_q <= idle_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Shadow/active coefficient banks with a drain-qualified atomic swap for the FIR.
module fir_coef_ctrl
    import fir_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_WAIT     = 64
) (
    input  logic            CLK,
    input  logic            RST_n,
    fir_coef_ctrl_if.slave  cfg,
    input  logic            VIN,
    output coef_t           H0,
    output coef_t           H1,
    output coef_t           H2,
    output coef_t           H3,
    output coef_t           H4,
    output coef_t           H5,
    output coef_t           H6,
    output coef_t           H7,
    output coef_t           H8
);

    localparam logic [3:0] MAX_ADDR = 4'(ORDER);

    ctrl_state_t state_q, state_d;
    coef_bank_t  shadow_q;
    coef_bank_t  active_q;
    logic        swap_d, swap_done_q;
    logic        forced_d, forced_q;
    logic        wr_err_q;
    logic        mon_clear, mon_en;
    logic        drained, timeout;
    logic        wr_ok, wr_bad;

    fir_drain_mon #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MAX_WAIT     (MAX_WAIT)
    ) u_drain_mon (
        .clk       (CLK),
        .rst_n     (RST_n),
        .clear_i   (mon_clear),
        .enable_i  (mon_en),
        .vin_i     (VIN),
        .drained_o (drained),
        .timeout_o (timeout)
    );

    assign wr_ok  = cfg.CFG_WE && (state_q == IDLE) && (cfg.CFG_ADDR <= MAX_ADDR);
    assign wr_bad = cfg.CFG_WE && ((state_q == PENDING) || (cfg.CFG_ADDR > MAX_ADDR));

    always_comb begin
        state_d   = state_q;
        swap_d    = 1'b0;
        forced_d  = 1'b0;
        mon_clear = 1'b0;
        mon_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.CFG_COMMIT) begin
                    state_d   = PENDING;
                    mon_clear = 1'b1;
                end
            end
            PENDING: begin
                mon_en = 1'b1;
                if (drained || timeout) begin
                    swap_d   = 1'b1;
                    state_d  = IDLE;
                    // A simultaneous drain counts as a clean swap.
                    forced_d = timeout && !drained;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes only happen in IDLE and swaps only in PENDING, so the banks never race.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            swap_done_q <= 1'b0;
            forced_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_done_q <= swap_d;
            forced_q    <= forced_d;
            if (wr_bad)
                wr_err_q <= 1'b1;
            if (wr_ok)
                shadow_q[cfg.CFG_ADDR] <= cfg.CFG_DATA;
            if (swap_d)
                active_q <= shadow_q;
        end
    end

    assign cfg.BUSY      = (state_q == PENDING);
    assign cfg.SWAP_DONE = swap_done_q;
    assign cfg.FORCED    = forced_q;
    assign cfg.WR_ERR    = wr_err_q;

    assign H0 = active_q[0];
    assign H1 = active_q[1];
    assign H2 = active_q[2];
    assign H3 = active_q[3];
    assign H4 = active_q[4];
    assign H5 = active_q[5];
    assign H6 = active_q[6];
    assign H7 = active_q[7];
    assign H8 = active_q[8];

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl with DRAIN_CYCLES=2 and MAX_WAIT=16.
module tb_fir_coef_ctrl;
    import fir_pkg::*;

    logic  CLK;
    logic  RST_n;
    logic  VIN;
    coef_t H0, H1, H2, H3, H4, H5, H6, H7, H8;
    coef_t h [0:8];

    int tests = 0;
    int fails = 0;

    fir_coef_ctrl_if bus ();

    fir_coef_ctrl #(
        .DRAIN_CYCLES (2),
        .MAX_WAIT     (16)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .cfg   (bus),
        .VIN   (VIN),
        .H0 (H0), .H1 (H1), .H2 (H2), .H3 (H3), .H4 (H4),
        .H5 (H5), .H6 (H6), .H7 (H7), .H8 (H8)
    );

    assign h[0] = H0; assign h[1] = H1; assign h[2] = H2;
    assign h[3] = H3; assign h[4] = H4; assign h[5] = H5;
    assign h[6] = H6; assign h[7] = H7; assign h[8] = H8;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.CFG_WE   = 1'b1;
        bus.CFG_ADDR = 4'(a);
        bus.CFG_DATA = coef_t'(d);
        tick();
        bus.CFG_WE   = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        RST_n          = 1'b0;
        VIN            = 1'b0;
        bus.CFG_WE     = 1'b0;
        bus.CFG_ADDR   = '0;
        bus.CFG_DATA   = '0;
        bus.CFG_COMMIT = 1'b0;
        #3;
        tick();
        tick();
        @(negedge CLK);
        RST_n = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(0)) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_h: %0d nonzero taps (H0=%0d), required all 0", bad, H0);
        end
        tests++;
        if ({bus.BUSY, bus.SWAP_DONE, bus.FORCED, bus.WR_ERR} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: BUSY/SD/FORCED/ERR=%b required 0000",
                     {bus.BUSY, bus.SWAP_DONE, bus.FORCED, bus.WR_ERR});
        end
    endtask

    task automatic test_drain_swap;
        int bad;
        for (int i = 0; i < 9; i++) wr(i, i + 1);
        VIN = 1'b0;
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        tests++;
        if ({bus.BUSY, bus.SWAP_DONE, H0} !== {1'b1, 1'b0, coef_t'(0)}) begin
            fails++;
            $display("FAIL drain_e0: BUSY=%b SD=%b H0=%0d required 1 0 0", bus.BUSY, bus.SWAP_DONE, H0);
        end
        tick();
        tests++;
        if ({bus.BUSY, bus.SWAP_DONE, H0} !== {1'b1, 1'b0, coef_t'(0)}) begin
            fails++;
            $display("FAIL drain_e1: BUSY=%b SD=%b H0=%0d required 1 0 0", bus.BUSY, bus.SWAP_DONE, H0);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(i + 1)) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL drain_h: %0d wrong taps (H0=%0d H8=%0d), required 1..9", bad, H0, H8);
        end
        tests++;
        if ({bus.BUSY, bus.SWAP_DONE, bus.FORCED} !== 3'b010) begin
            fails++;
            $display("FAIL drain_e2_flags: BUSY/SD/FORCED=%b required 010",
                     {bus.BUSY, bus.SWAP_DONE, bus.FORCED});
        end
        tick();
        tests++;
        if (bus.SWAP_DONE !== 1'b0) begin
            fails++;
            $display("FAIL drain_pulse: SWAP_DONE=%b required 0", bus.SWAP_DONE);
        end
    endtask

    task automatic test_vin_pattern;
        logic pat [1:5];
        int   early;
        int   bad;
        pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b0;
        for (int i = 0; i < 9; i++) wr(i, -4096);
        bus.CFG_COMMIT = 1'b1;
        tick();
        early = 0;
        for (int k = 1; k <= 5; k++) begin
            VIN = pat[k];
            // Re-committing while pending must neither restart nor flag an error.
            bus.CFG_COMMIT = (k == 2);
            tick();
            if (k < 5 && (bus.SWAP_DONE !== 1'b0 || bus.BUSY !== 1'b1)) early++;
        end
        bus.CFG_COMMIT = 1'b0;
        VIN = 1'b0;
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL pattern_early: %0d early swap/idle cycles, required 0", early);
        end
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(-4096)) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL pattern_h: %0d wrong taps (H0=%0d), required -4096", bad, H0);
        end
        tests++;
        if ({bus.SWAP_DONE, bus.FORCED, bus.BUSY, bus.WR_ERR} !== 4'b1000) begin
            fails++;
            $display("FAIL pattern_flags: SD/FORCED/BUSY/ERR=%b required 1000",
                     {bus.SWAP_DONE, bus.FORCED, bus.BUSY, bus.WR_ERR});
        end
        tick();
    endtask

    task automatic test_forced;
        int early;
        int bad;
        for (int i = 0; i < 9; i++) wr(i, 100 + i);
        VIN = 1'b1;
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.SWAP_DONE !== 1'b0 || bus.BUSY !== 1'b1 || H0 !== coef_t'(-4096)) early++;
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL forced_early: %0d bad cycles before edge 16, required 0", early);
        end
        tick();
        tests++;
        if ({bus.SWAP_DONE, bus.FORCED, bus.BUSY} !== 3'b110) begin
            fails++;
            $display("FAIL forced_flags: SD/FORCED/BUSY=%b required 110",
                     {bus.SWAP_DONE, bus.FORCED, bus.BUSY});
        end
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(100 + i)) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL forced_h: %0d wrong taps (H0=%0d), required 100..108", bad, H0);
        end
        tick();
        tests++;
        if ({bus.SWAP_DONE, bus.FORCED} !== 2'b00) begin
            fails++;
            $display("FAIL forced_pulse: SD/FORCED=%b required 00", {bus.SWAP_DONE, bus.FORCED});
        end
        VIN = 1'b0;
    endtask

    task automatic test_tie;
        wr(0, 200);
        VIN = 1'b1;
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            VIN = (k <= 14);
            tick();
        end
        tests++;
        if ({bus.SWAP_DONE, bus.FORCED, H0} !== {1'b1, 1'b0, coef_t'(200)}) begin
            fails++;
            $display("FAIL tie: SD=%b FORCED=%b H0=%0d required 1 0 200", bus.SWAP_DONE, bus.FORCED, H0);
        end
        VIN = 1'b0;
        tick();
    endtask

    task automatic test_wr_err;
        wr(9, 777);
        tests++;
        if ({bus.WR_ERR, H0} !== {1'b1, coef_t'(200)}) begin
            fails++;
            $display("FAIL err_addr: WR_ERR=%b H0=%0d required 1 200", bus.WR_ERR, H0);
        end
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        wr(0, 555);
        tick();
        tests++;
        if ({bus.SWAP_DONE, H0, bus.WR_ERR} !== {1'b1, coef_t'(200), 1'b1}) begin
            fails++;
            $display("FAIL err_busy_write: SD=%b H0=%0d ERR=%b required 1 200 1", bus.SWAP_DONE, H0, bus.WR_ERR);
        end
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        tick();
        tick();
        tests++;
        if ({H0, H1, bus.WR_ERR} !== {coef_t'(200), coef_t'(101), 1'b1}) begin
            fails++;
            $display("FAIL err_sticky: H0=%0d H1=%0d ERR=%b required 200 101 1", H0, H1, bus.WR_ERR);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        bus.CFG_WE     = 1'b1;
        bus.CFG_ADDR   = 4'd0;
        bus.CFG_DATA   = coef_t'(50);
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_WE     = 1'b0;
        bus.CFG_COMMIT = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus.SWAP_DONE, H0, H8} !== {1'b1, coef_t'(50), coef_t'(108)}) begin
            fails++;
            $display("FAIL same_edge: SD=%b H0=%0d H8=%0d required 1 50 108", bus.SWAP_DONE, H0, H8);
        end
        tick();
    endtask

    task automatic test_reset_pending;
        int bad;
        int late;
        for (int i = 0; i < 9; i++) wr(i, i + 1);
        VIN = 1'b1;
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        tick();
        RST_n = 1'b0;
        #2;
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(0)) bad++;
        tests++;
        if (bad !== 0 || {bus.BUSY, bus.WR_ERR} !== 2'b00) begin
            fails++;
            $display("FAIL rst_pending: %0d nonzero taps BUSY=%b ERR=%b required 0 0 0", bad, bus.BUSY, bus.WR_ERR);
        end
        VIN = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        late = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.SWAP_DONE !== 1'b0 || bus.BUSY !== 1'b0 || H4 !== coef_t'(0)) late++;
        end
        tests++;
        if (late !== 0) begin
            fails++;
            $display("FAIL rst_no_swap: %0d cycles with swap/busy/taps, required 0", late);
        end
        bus.CFG_COMMIT = 1'b1;
        tick();
        bus.CFG_COMMIT = 1'b0;
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < 9; i++) if (h[i] !== coef_t'(0)) bad++;
        tests++;
        if (bad !== 0 || bus.SWAP_DONE !== 1'b1) begin
            fails++;
            $display("FAIL rst_shadow_cleared: %0d nonzero taps SD=%b required 0 1", bad, bus.SWAP_DONE);
        end
    endtask

    initial begin
        test_reset();
        test_drain_swap();
        test_vin_pattern();
        test_forced();
        test_tie();
        test_wr_err();
        test_back_to_back();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
Run-time coefficient configurator for the 9-tap FIR (myfir, ORDER=8, DATA_WIDTH=13).
- A host writes coefficients into a shadow bank through a simple write port, then issues a commit.
- The block drives the FIR's H0..H8 from an active bank.
- It copies shadow to active atomically, and only when the sample stream has been idle long enough for the FIR pipeline to drain.
- A timeout forces the swap if the stream never goes idle.

Parameters:
- ORDER, 8, filter order; ORDER+1 coefficients.
- DATA_WIDTH, 13, signed coefficient width.
- DRAIN_CYCLES, 2, consecutive idle samples of VIN required before swap; must be >=1.
- MAX_WAIT, 64, edges spent in PENDING before a forced swap; must be >=DRAIN_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- CFG_WE  in  1  shadow-bank write strobe.
- CFG_ADDR  in  4  coefficient index, valid range 0..ORDER.
- CFG_DATA  in  DATA_WIDTH  signed coefficient value.
- CFG_COMMIT  in  1  request shadow-to-active swap (single-cycle pulse expected).
- VIN  in  1  sample-valid into the FIR; monitored only, never gated.
- H0..H8  out  DATA_WIDTH each  active signed coefficients to the FIR.
- BUSY  out  1  high while a commit is pending.
- SWAP_DONE  out  1  one-cycle pulse after the active bank is updated.
- FORCED  out  1  one-cycle pulse with SWAP_DONE when the swap was timeout-forced.
- WR_ERR  out  1  sticky error flag; cleared only by reset.

Behaviour:
Reset (asynchronous, RST_n=0):
- Shadow and active banks go to 0, so H0..H8=0.
- State=IDLE; BUSY, SWAP_DONE, FORCED and WR_ERR go to 0; all counters go to 0.
- Reset during PENDING discards the commit; active coefficients stay 0.

All outputs are registered.

States are IDLE and PENDING. BUSY=1 exactly while state=PENDING.

Shadow writes:
- On an edge with CFG_WE=1, state=IDLE and CFG_ADDR<=ORDER: shadow[CFG_ADDR] <= CFG_DATA.
- CFG_WE=1 with CFG_ADDR>ORDER: no write, WR_ERR <= 1.
- CFG_WE=1 while PENDING: no write, WR_ERR <= 1.
- CFG_WE and CFG_COMMIT on the same IDLE edge: the write is performed and is included in the pending swap.

IDLE to PENDING:
- On an edge with CFG_COMMIT=1 in IDLE, state becomes PENDING.
- idle_cnt and wait_cnt are cleared to 0.
- CFG_COMMIT while PENDING is ignored: no restart, no error.

PENDING, evaluated on every edge:
- wait_cnt <= wait_cnt+1.
- If VIN=0, idle_cnt <= idle_cnt+1 (saturating at DRAIN_CYCLES); else idle_cnt <= 0.
- Drain condition: VIN=0 and idle_cnt==DRAIN_CYCLES-1.
- Timeout condition: wait_cnt==MAX_WAIT-1.
- If either condition holds:
  - active <= shadow (all ORDER+1 entries on the same edge);
  - state <= IDLE;
  - SWAP_DONE <= 1;
  - FORCED <= 1 only if the timeout holds and the drain condition does not (drain wins on a tie).
- SWAP_DONE and FORCED return to 0 on the next edge.

Latency:
- With VIN held low from the commit onward, H0..H8 change exactly DRAIN_CYCLES edges after the commit edge, together with SWAP_DONE=1.
- Forced swap: exactly MAX_WAIT edges after the commit edge.

Arithmetic and width:
- Coefficients pass through bit-exact; there is no arithmetic on coefficient data.
- Counters are sized $clog2(MAX_WAIT+1).
- H outputs never glitch between swaps: only the swap edge loads them.

Decomposition:
- Package fir_pkg holds:
  - constants ORDER and DATA_WIDTH;
  - typedef coef_t = logic signed [DATA_WIDTH-1:0];
  - typedef coef_bank_t = coef_t [0:ORDER];
  - enum ctrl_state_t {IDLE, PENDING}.
- One sub-module, fir_drain_mon, contains idle_cnt and wait_cnt.
  - Inputs: clear, enable, VIN.
  - Outputs: drained, timeout.
- The top level holds both banks, the FSM and the flags.

Test Plan:
1. Reset release with all inputs low -> H0..H8=0, BUSY=0, SWAP_DONE=0, FORCED=0, WR_ERR=0.
2. Write H[i]=i+1 for i=0..8, commit, VIN=0 (DRAIN_CYCLES=2) -> H0..H8=1..9 exactly 2 edges after commit, one SWAP_DONE pulse, FORCED=0, BUSY high for 2 cycles.
3. Shadow loaded with -4096 in all entries, commit, VIN pattern 1,0,1,0,0 -> swap on the edge of the second consecutive 0 (5th edge after commit), H all =-4096.
4. VIN held 1, MAX_WAIT=16, commit -> swap on the 16th edge after commit, SWAP_DONE and FORCED pulse together.
5. Write to addr 9, then write to addr 0 while BUSY -> WR_ERR=1 sticky, shadow[0] unchanged (confirmed by next commit).
6. RST_n pulsed low mid-PENDING with shadow=1..9 -> H stays 0, BUSY=0, no SWAP_DONE after release.
